// File: rtl/cac_command_parser_pkg.sv
// Shared constants and state encodings for the CAC command parser and its response serializer.
package cac_command_parser_pkg;

    localparam logic [7:0] SOF_BYTE     = 8'hA5;
    localparam logic [7:0] ACK_BYTE     = 8'h5A;
    localparam logic [7:0] CMD_WR       = 8'h01;
    localparam logic [7:0] CMD_RD       = 8'h02;
    localparam logic [7:0] STAT_OK      = 8'h00;
    localparam logic [7:0] STAT_BAD_CHK = 8'h01;
    localparam logic [7:0] STAT_BAD_CMD = 8'h02;

    typedef enum logic [2:0] {
        P_IDLE   = 3'd0,
        P_CMD    = 3'd1,
        P_ADDR   = 3'd2,
        P_DATA   = 3'd3,
        P_CHK    = 3'd4,
        P_EXEC   = 3'd5,
        P_RDWAIT = 3'd6,
        P_RESP   = 3'd7
    } parser_state_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SOF    = 3'd1,
        S_STATUS = 3'd2,
        S_DATA   = 3'd3,
        S_RCHK   = 3'd4
    } ser_state_e;

endpackage

// File: rtl/cac_resp_serializer.sv
// Captures STATUS and an optional data word on load, then emits 0x5A, STATUS, data bytes (MSB first), RCHK.
// tx_valid/tx_ready: a byte moves only on a cycle where both are high; tx_data is held otherwise.
module cac_resp_serializer
    import cac_command_parser_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_cac,
    input  logic          rst_cac,
    input  logic          load,
    input  logic [7:0]    load_status,
    input  logic [DW-1:0] load_data,
    input  logic          load_with_data,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          done,
    output logic [2:0]    dbg_state
);
    localparam int NB = DW / 8;

    ser_state_e    state_q, state_d;
    logic [7:0]    status_q, status_d;
    logic [DW-1:0] data_q, data_d;
    logic          with_q, with_d;
    logic [7:0]    rchk_q, rchk_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    data_xor;
    logic          hs;

    always_comb begin
        data_xor = '0;
        for (int i = 0; i < NB; i++) data_xor = data_xor ^ load_data[i*8 +: 8];
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        data_d   = data_q;
        with_d   = with_q;
        rchk_d   = rchk_q;
        cnt_d    = cnt_q;
        done     = 1'b0;
        tx_valid = (state_q != S_IDLE);
        hs       = tx_valid && tx_ready;
        unique case (state_q)
            S_SOF:    tx_data = ACK_BYTE;
            S_STATUS: tx_data = status_q;
            S_DATA:   tx_data = data_q[DW-1 -: 8];
            S_RCHK:   tx_data = rchk_q;
            default:  tx_data = 8'h00;
        endcase
        unique case (state_q)
            S_IDLE: if (load) begin
                status_d = load_status;
                data_d   = load_data;
                with_d   = load_with_data;
                rchk_d   = load_with_data ? (load_status ^ data_xor) : load_status;
                cnt_d    = '0;
                state_d  = S_SOF;
            end
            S_SOF:    if (hs) state_d = S_STATUS;
            S_STATUS: if (hs) state_d = with_q ? S_DATA : S_RCHK;
            S_DATA: if (hs) begin
                data_d = data_q << 8;
                cnt_d  = cnt_q + 8'd1;
                if (cnt_q == 8'(NB - 1)) state_d = S_RCHK;
            end
            S_RCHK: if (hs) begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_cac) begin
        if (rst_cac) begin
            state_q  <= S_IDLE;
            status_q <= '0;
            data_q   <= '0;
            with_q   <= 1'b0;
            rchk_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            data_q   <= data_d;
            with_q   <= with_d;
            rchk_q   <= rchk_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: rtl/cac_command_parser.sv
// Byte-level frame parser: decodes write/read frames, checks the XOR checksum, issues one settings
// access per good frame and hands STATUS (plus read data) to the response serializer.
module cac_command_parser
    import cac_command_parser_pkg::*;
#(
    parameter int CAC_UART_CH_BUFFER_WIDTH        = 8,
    parameter int CAC_UART_CH_SETTINGS_ADDR_WIDTH = 8,
    parameter int CAC_UART_CH_SETTINGS_DATA_WIDTH = 32,
    parameter int CAC_TIMEOUT_CYCLES              = 10000
) (
    input  logic                                       clk_cac,
    input  logic                                       rst_cac,
    input  logic [CAC_UART_CH_BUFFER_WIDTH-1:0]        rx_data,
    input  logic                                       rx_valid,
    input  logic                                       rx_error,
    output logic [CAC_UART_CH_BUFFER_WIDTH-1:0]        tx_data,
    output logic                                       tx_valid,
    input  logic                                       tx_ready,
    output logic                                       set_wr_en,
    output logic                                       set_rd_en,
    output logic [CAC_UART_CH_SETTINGS_ADDR_WIDTH-1:0] set_addr,
    output logic [CAC_UART_CH_SETTINGS_DATA_WIDTH-1:0] set_wdata,
    input  logic [CAC_UART_CH_SETTINGS_DATA_WIDTH-1:0] set_rdata,
    output logic                                       err_chk,
    output logic                                       err_timeout,
    output logic [2:0]                                 dbg_state,
    output logic [2:0]                                 dbg_ser_state
);
    localparam int AW = CAC_UART_CH_SETTINGS_ADDR_WIDTH;
    localparam int DW = CAC_UART_CH_SETTINGS_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam logic [15:0] GAP_LAST = 16'(CAC_TIMEOUT_CYCLES - 1);

    parser_state_e state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [7:0]    acc_q, acc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [15:0]   gap_q, gap_d;
    logic [7:0]    status_q, status_d;
    logic          ser_load;
    logic          ser_done;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        status_d    = status_q;
        set_wr_en   = 1'b0;
        set_rd_en   = 1'b0;
        err_chk     = 1'b0;
        err_timeout = 1'b0;
        ser_load    = 1'b0;
        unique case (state_q)
            P_IDLE: if (rx_valid && rx_data == SOF_BYTE) begin
                acc_d   = '0;
                cnt_d   = '0;
                gap_d   = '0;
                state_d = P_CMD;
            end
            P_CMD, P_ADDR, P_DATA, P_CHK: begin
                if (rx_error) begin
                    state_d = P_IDLE;
                end else if (rx_valid) begin
                    // An arriving byte beats a simultaneous terminal count.
                    gap_d = '0;
                    acc_d = acc_q ^ rx_data;
                    unique case (state_q)
                        P_CMD: begin
                            cmd_d   = rx_data;
                            state_d = P_ADDR;
                        end
                        P_ADDR: begin
                            addr_d  = rx_data;
                            cnt_d   = '0;
                            state_d = (cmd_q == CMD_WR) ? P_DATA : P_CHK;
                        end
                        P_DATA: begin
                            data_d = (data_q << 8) | DW'(rx_data);
                            cnt_d  = cnt_q + 8'd1;
                            if (cnt_q == 8'(NB - 1)) state_d = P_CHK;
                        end
                        default: begin
                            if (acc_q != rx_data)
                                status_d = STAT_BAD_CHK;
                            else if (cmd_q != CMD_WR && cmd_q != CMD_RD)
                                status_d = STAT_BAD_CMD;
                            else
                                status_d = STAT_OK;
                            state_d = P_EXEC;
                        end
                    endcase
                end else if (gap_q == GAP_LAST) begin
                    err_timeout = 1'b1;
                    state_d     = P_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            P_EXEC: begin
                err_chk = (status_q == STAT_BAD_CHK);
                if (status_q == STAT_OK && cmd_q == CMD_RD) begin
                    set_rd_en = 1'b1;
                    state_d   = P_RDWAIT;
                end else begin
                    set_wr_en = (status_q == STAT_OK);
                    ser_load  = 1'b1;
                    state_d   = P_RESP;
                end
            end
            P_RDWAIT: begin
                ser_load = 1'b1;
                state_d  = P_RESP;
            end
            P_RESP: if (ser_done) state_d = P_IDLE;
            default: state_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk_cac) begin
        if (rst_cac) begin
            state_q  <= P_IDLE;
            cmd_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            status_q <= status_d;
        end
    end

    assign set_addr  = AW'(addr_q);
    assign set_wdata = data_q;
    assign dbg_state = state_q;

    // Read data is taken straight from set_rdata during RDWAIT, its only valid cycle.
    cac_resp_serializer #(.DW(DW)) u_resp (
        .clk_cac        (clk_cac),
        .rst_cac        (rst_cac),
        .load           (ser_load),
        .load_status    (status_q),
        .load_data      (set_rdata),
        .load_with_data (state_q == P_RDWAIT),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .done           (ser_done),
        .dbg_state      (dbg_ser_state)
    );

endmodule
